inv_keyexpansion: RTL

- Generates AES-128 round keys in reverse order (round 10 down to round 0) for the decryption datapath. It is the inverse counterpart of the forward key expansion.
- The block is loaded with the round-10 key, then steps back one round per request.
- It sits beside the inverse-cipher round engine, which consumes rk each round.
- It reuses the existing SBox cell (ports B in, D out, combinational).

---
 rtl/inv_keyexpansion.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/inv_keyexpansion.sv
// ---------------------------------------------------------------------------
// inv_keyexpansion
//   Produces AES-128 round keys in reverse order (round 10 down to round 0)
//   for the inverse-cipher datapath. Loaded with the round-10 key, it steps
//   back one round per request, one key per cycle while step is held.
//
//   Optional build macro INV_KEY_FWD_EN: load takes the cipher key instead.
//   The block runs the forward expansion internally (busy=1) for 10 cycles,
//   then presents the round-10 key and continues as in the default build.
//
// Ports
//   CLK    in   1    clock, rising edge
//   RST    in   1    asynchronous active-high reset
//   load   in   1    capture key (priority over step)
//   step   in   1    request previous round key
//   key    in   128  round-10 key (cipher key with INV_KEY_FWD_EN)
//   rk     out  128  current round key, w0 = rk[127:96] .. w3 = rk[31:0]
//   round  out  4    round index of rk
//   valid  out  1    rk holds a legal round key
//   done   out  1    valid and round == 0
//   busy   out  1    forward expansion running (0 without the macro)
//
//   State | meaning
//   IDLE  | after reset, no key loaded, step ignored
//   REV   | rk valid, step walks back one round
//   FWD   | forward expansion from cipher key (macro builds only)
// ---------------------------------------------------------------------------

module SBox (
    input  logic [7:0] B,
    output logic [7:0] D
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so index from the top: (255-B)*8 == {~B,3'b0}.
    assign D = TBL[{~B, 3'b000} +: 8];
endmodule

module inv_keyexpansion #(
    parameter int NR = 10   // only 10 (AES-128) is supported
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         step,
    input  logic [127:0] key,
    output logic [127:0] rk,
    output logic [3:0]   round,
    output logic         valid,
    output logic         done,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REV  = 2'd1,
        S_FWD  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;

    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h01;
            4'd1:    b = 8'h02;
            4'd2:    b = 8'h04;
            4'd3:    b = 8'h08;
            4'd4:    b = 8'h10;
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h40;
            4'd7:    b = 8'h80;
            4'd8:    b = 8'h1b;
            4'd9:    b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t0, t1, t2, t3;
    logic [31:0] sub_in, rot, subrot;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    // Inverse step: previous w3 is recovered first, it feeds SubRot.
    assign t3 = w3 ^ w2;
    assign t2 = w2 ^ w1;
    assign t1 = w1 ^ w0;

`ifdef INV_KEY_FWD_EN
    // Shared SBox row: forward rounds use w3, reverse rounds use w2^w3.
    assign sub_in = (state_q == S_FWD) ? w3 : t3;
`else
    assign sub_in = t3;
`endif

    assign rot = {sub_in[23:0], sub_in[31:24]};

    SBox u_sb3 (.B(rot[31:24]), .D(subrot[31:24]));
    SBox u_sb2 (.B(rot[23:16]), .D(subrot[23:16]));
    SBox u_sb1 (.B(rot[15:8]),  .D(subrot[15:8]));
    SBox u_sb0 (.B(rot[7:0]),   .D(subrot[7:0]));

    assign t0 = w0 ^ subrot ^ rcon(round_q - 4'd1);

`ifdef INV_KEY_FWD_EN
    logic [31:0] f0, f1, f2, f3;
    // During FWD round_q counts the forward round index k = 0..NR-1.
    assign f0 = w0 ^ subrot ^ rcon(round_q);
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            rk_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        if (load) begin
            rk_d = key;
`ifdef INV_KEY_FWD_EN
            state_d = S_FWD;
            round_d = 4'd0;
`else
            state_d = S_REV;
            round_d = 4'(NR);
`endif
        end else begin
            case (state_q)
                S_REV: begin
                    if (step && (round_q != 4'd0)) begin
                        rk_d    = {t0, t1, t2, t3};
                        round_d = round_q - 4'd1;
                    end
                end
`ifdef INV_KEY_FWD_EN
                S_FWD: begin
                    rk_d = {f0, f1, f2, f3};
                    if (round_q == 4'(NR - 1)) begin
                        state_d = S_REV;
                        round_d = 4'(NR);
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rk    = rk_q;
        round = round_q;
        valid = (state_q == S_REV);
        done  = (state_q == S_REV) && (round_q == 4'd0);
`ifdef INV_KEY_FWD_EN
        busy  = (state_q == S_FWD);
`else
        busy  = 1'b0;
`endif
    end
endmodule
